slice_column_scheduler: RTL and testbench

Sequences the per-column slice-height calculator across one screen width per frame. On a frame request it snapshots the player pose so every column of the frame uses the same pose. It then issues one calculation per column, in order, and buffers each `{column, height}` result in a small FIFO for the slice drawer. It sits between the frame/game-state logic and `find_slice_height` on one side, and the column drawing logic on the other.

---
 rtl/slice_column_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_slice_column_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_column_scheduler.sv
// slice_column_scheduler: steps find_slice_height across every column of a frame
// using a pose snapshot taken at frame start, and queues {column, height}
// results in a small first-word-fall-through FIFO for the slice drawer.
// Optional macro SLICE_SCHED_TIMEOUT_EN adds a per-column wait timeout that
// pushes a zero-height slice and raises a sticky timeout_flag.
module slice_column_scheduler #(
    parameter int unsigned NUM_COLS       = 160,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_start,
    input  logic signed [12:0] playerX,
    input  logic signed [12:0] playerY,
    input  logic signed [9:0]  angle_X,
    input  logic signed [9:0]  angle_Y,
    output logic signed [12:0] calc_playerX,
    output logic signed [12:0] calc_playerY,
    output logic signed [9:0]  calc_angle_X,
    output logic signed [9:0]  calc_angle_Y,
    output logic [7:0]         calc_column,
    output logic               calc_begin,
    input  logic               calc_done,
    input  logic [6:0]         calc_height,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_column,
    output logic [6:0]         out_height,
    output logic               busy,
    output logic               frame_done,
    output logic               timeout_flag
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [7:0] LastCol = 8'(NUM_COLS - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

    state_e state_q, state_d;

    logic signed [12:0] pose_x_q, pose_x_d;
    logic signed [12:0] pose_y_q, pose_y_d;
    logic signed [9:0]  ang_x_q, ang_x_d;
    logic signed [9:0]  ang_y_q, ang_y_d;
    logic [7:0]         column_q, column_d;

    logic [14:0]        mem_q [FIFO_DEPTH];
    logic [14:0]        mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;

    logic frame_accept;
    logic has_space;
    logic fifo_empty;
    logic timeout_hit;
    logic push;
    logic pop;
    logic [6:0] push_height;

    assign frame_accept = (state_q == StIdle) && frame_start;
    // Space is judged on the registered count so a reserved slot never depends on a same-cycle pop.
    assign has_space    = (count_q < DepthCnt);
    assign fifo_empty   = (count_q == '0);
    // A result (real or timed out) is taken only while waiting; stray calc_done is dropped.
    assign push         = (state_q == StWait) && (calc_done || timeout_hit);
    assign push_height  = calc_done ? calc_height : 7'd0;
    assign pop          = out_valid && out_ready;

`ifdef SLICE_SCHED_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       flag_q, flag_d;

    // calc_done arriving on the timeout cycle takes priority over the timeout.
    assign timeout_hit = (state_q == StWait) && !calc_done
                         && (wait_cnt_q == 8'(TIMEOUT_CYCLES));

    // Wait counter: held at zero outside WAIT so every WAIT entry starts from zero.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q != StWait) begin
            wait_cnt_d = 8'd0;
        end else if (!calc_done) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Sticky timeout flag, cleared by an accepted frame request.
    always_comb begin
        flag_d = flag_q;
        if (frame_accept) begin
            flag_d = 1'b0;
        end else if (timeout_hit) begin
            flag_d = 1'b1;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= 8'd0;
            flag_q     <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            flag_q     <= flag_d;
        end
    end

    assign timeout_flag = flag_q;
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (frame_start) state_d = StIssue;
            StIssue: if (has_space) state_d = StWait;
            StWait: begin
                if (push) begin
                    state_d = (column_q == LastCol) ? StDrain : StIssue;
                end
            end
            StDrain: if (fifo_empty) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        calc_begin = (state_q == StIssue) && has_space;
        frame_done = (state_q == StDrain) && fifo_empty;
        busy       = (state_q != StIdle);
    end

    // Pose snapshot and column counter next-state.
    always_comb begin
        pose_x_d = pose_x_q;
        pose_y_d = pose_y_q;
        ang_x_d  = ang_x_q;
        ang_y_d  = ang_y_q;
        column_d = column_q;
        if (frame_accept) begin
            pose_x_d = playerX;
            pose_y_d = playerY;
            ang_x_d  = angle_X;
            ang_y_d  = angle_Y;
            column_d = 8'd0;
        end else if (push && (column_q != LastCol)) begin
            column_d = column_q + 8'd1;
        end
    end

    // Pose and column registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pose_x_q <= '0;
            pose_y_q <= '0;
            ang_x_q  <= '0;
            ang_y_q  <= '0;
            column_q <= 8'd0;
        end else begin
            pose_x_q <= pose_x_d;
            pose_y_q <= pose_y_d;
            ang_x_q  <= ang_x_d;
            ang_y_q  <= ang_y_d;
            column_q <= column_d;
        end
    end

    assign calc_playerX = pose_x_q;
    assign calc_playerY = pose_y_q;
    assign calc_angle_X = ang_x_q;
    assign calc_angle_Y = ang_y_q;
    assign calc_column  = column_q;

    // Result FIFO next-state: pointers wrap naturally since the depth is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {column_q, push_height};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Result FIFO registers; reset also discards any buffered results.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_valid  = !fifo_empty;
    assign out_column = mem_q[rd_ptr_q][14:7];
    assign out_height = mem_q[rd_ptr_q][6:0];

endmodule

// File: tb/tb_slice_column_scheduler.sv
// Directed bench for slice_column_scheduler with a 3-cycle calculator model.
module tb_slice_column_scheduler;

    logic               clock;
    logic               reset;
    logic               frame_start;
    logic signed [12:0] playerX;
    logic signed [12:0] playerY;
    logic signed [9:0]  angle_X;
    logic signed [9:0]  angle_Y;
    logic signed [12:0] calc_playerX;
    logic signed [12:0] calc_playerY;
    logic signed [9:0]  calc_angle_X;
    logic signed [9:0]  calc_angle_Y;
    logic [7:0]         calc_column;
    logic               calc_begin;
    logic               calc_done;
    logic [6:0]         calc_height;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_column;
    logic [6:0]         out_height;
    logic               busy;
    logic               frame_done;
    logic               timeout_flag;

    int total = 0;
    int bad   = 0;

    slice_column_scheduler #(
        .NUM_COLS      (4),
        .FIFO_DEPTH    (2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .playerX     (playerX),
        .playerY     (playerY),
        .angle_X     (angle_X),
        .angle_Y     (angle_Y),
        .calc_playerX(calc_playerX),
        .calc_playerY(calc_playerY),
        .calc_angle_X(calc_angle_X),
        .calc_angle_Y(calc_angle_Y),
        .calc_column (calc_column),
        .calc_begin  (calc_begin),
        .calc_done   (calc_done),
        .calc_height (calc_height),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_column  (out_column),
        .out_height  (out_height),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_flag(timeout_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Event counters and popped-entry scoreboard.
    int       begin_cnt = 0;
    int       done_cnt  = 0;
    int       sb_col [$];
    int       sb_hgt [$];

    always @(posedge clock) begin
        if (!reset) begin
            if (calc_begin) begin_cnt++;
            if (frame_done) done_cnt++;
            if (out_valid && out_ready) begin
                sb_col.push_back(int'(out_column));
                sb_hgt.push_back(int'(out_height));
            end
        end
    end

    // Calculator model: done 3 cycles after begin, height = column + 10; can stay silent.
    logic mute_en  = 1'b0;
    int   mute_col = 0;
    logic mdl_pending;
    int   mdl_cnt;
    int   mdl_col;

    initial begin
        calc_done   = 1'b0;
        calc_height = 7'd0;
        mdl_pending = 1'b0;
        mdl_cnt     = 0;
        mdl_col     = 0;
        forever begin
            @(negedge clock);
            calc_done = 1'b0;
            if (reset) begin
                mdl_pending = 1'b0;
            end else begin
                if (mdl_pending) begin
                    mdl_cnt--;
                    if (mdl_cnt == 0) begin
                        calc_done   = 1'b1;
                        calc_height = 7'(mdl_col + 10);
                        mdl_pending = 1'b0;
                    end
                end else if (calc_begin) begin
                    mdl_col = int'(calc_column);
                    if (!(mute_en && mdl_col == mute_col)) begin
                        mdl_pending = 1'b1;
                        mdl_cnt     = 3;
                    end
                end
            end
        end
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Pulse frame_start for one cycle; returns at the negedge of the following cycle.
    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_frame_done(input int budget, input string tag);
        logic got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_begin_col(input int col, input int budget, input string tag);
        logic got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (calc_begin && int'(calc_column) == col) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic check_entries(input int base, input string tag);
        check({tag, "_n"}, 32'(sb_col.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (sb_col.size() > base + i) begin
                check($sformatf("%s_col%0d", tag, i), 32'(sb_col[base + i]), 32'(i));
                check($sformatf("%s_hgt%0d", tag, i), 32'(sb_hgt[base + i]), 32'(i + 10));
            end
        end
    endtask

    initial begin
        int sb_base;
        int bc_base;
        int fd_base;

        reset       = 1'b1;
        frame_start = 1'b0;
        out_ready   = 1'b0;
        playerX     = 13'sd100;
        playerY     = -13'sd20;
        angle_X     = 10'sd5;
        angle_Y     = -10'sd3;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state.
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_begin", 32'(calc_begin), 32'd0);
        check("rst_col", 32'(calc_column), 32'd0);
        check("rst_px", 32'(calc_playerX), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ocol", 32'(out_column), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_tflag", 32'(timeout_flag), 32'd0);

        // Basic frame with pose snapshot and an ignored mid-frame request.
        out_ready = 1'b1;
        sb_base   = sb_col.size();
        bc_base   = begin_cnt;
        fd_base   = done_cnt;
        frame_pulse();
        check("basic_begin_t1", 32'(calc_begin), 32'd1);
        check("basic_col_t1", 32'(calc_column), 32'd0);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_px", 32'(calc_playerX), 32'(13'sd100));
        check("basic_py", 32'(calc_playerY), 32'(-13'sd20));
        check("basic_ay", 32'(calc_angle_Y), 32'(-10'sd3));
        tick();
        playerX = 13'sd500;
        frame_pulse();
        check("pose_hold_mid", 32'(calc_playerX), 32'(13'sd100));
        wait_frame_done(200, "basic_frame_done");
        tick();
        check("basic_busy_after", 32'(busy), 32'd0);
        check("basic_begins", 32'(begin_cnt - bc_base), 32'd4);
        check("basic_done_pulses", 32'(done_cnt - fd_base), 32'd1);
        check("pose_hold_end", 32'(calc_playerX), 32'(13'sd100));
        check_entries(sb_base, "basic");

        // Backpressure: the FIFO of 2 fills and issue stalls.
        repeat (2) tick();
        out_ready = 1'b0;
        sb_base   = sb_col.size();
        bc_base   = begin_cnt;
        frame_pulse();
        check("bp_new_pose", 32'(calc_playerX), 32'(13'sd500));
        repeat (40) tick();
        check("bp_begins_held", 32'(begin_cnt - bc_base), 32'd2);
        check("bp_begin_low", 32'(calc_begin), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_head_col", 32'(out_column), 32'd0);
        check("bp_head_hgt", 32'(out_height), 32'd10);
        out_ready = 1'b1;
        wait_frame_done(200, "bp_frame_done");
        check("bp_begins_total", 32'(begin_cnt - bc_base), 32'd4);
        check_entries(sb_base, "bp");

        // Simultaneous push and pop with one entry buffered.
        repeat (2) tick();
        out_ready = 1'b0;
        sb_base   = sb_col.size();
        frame_pulse();
        wait_begin_col(1, 50, "sim_begin_c1");
        repeat (3) tick();
        check("sim_pre_valid", 32'(out_valid), 32'd1);
        check("sim_pre_col", 32'(out_column), 32'd0);
        out_ready = 1'b1;
        tick();
        check("sim_post_valid", 32'(out_valid), 32'd1);
        check("sim_post_col", 32'(out_column), 32'd1);
        check("sim_post_hgt", 32'(out_height), 32'd11);
        wait_frame_done(200, "sim_frame_done");
        check_entries(sb_base, "sim");

        // Reset while waiting on column 2.
        repeat (2) tick();
        fd_base = done_cnt;
        frame_pulse();
        wait_begin_col(2, 50, "rmf_begin_c2");
        tick();
        reset = 1'b1;
        tick();
        check("rmf_busy", 32'(busy), 32'd0);
        check("rmf_begin", 32'(calc_begin), 32'd0);
        check("rmf_col", 32'(calc_column), 32'd0);
        check("rmf_px", 32'(calc_playerX), 32'd0);
        check("rmf_valid", 32'(out_valid), 32'd0);
        check("rmf_ocol", 32'(out_column), 32'd0);
        check("rmf_ohgt", 32'(out_height), 32'd0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rmf_no_done", 32'(done_cnt - fd_base), 32'd0);
        check("rmf_idle", 32'(busy), 32'd0);
        frame_pulse();
        check("rmf_restart_begin", 32'(calc_begin), 32'd1);
        check("rmf_restart_col", 32'(calc_column), 32'd0);
        wait_frame_done(200, "rmf_frame_done");

`ifdef SLICE_SCHED_TIMEOUT_EN
        // Calculator never answers column 1.
        repeat (2) tick();
        mute_en  = 1'b1;
        mute_col = 1;
        frame_pulse();
        wait_begin_col(1, 50, "to_begin_c1");
        repeat (9) tick();
        check("to_begin_low", 32'(calc_begin), 32'd0);
        check("to_flag_pre", 32'(timeout_flag), 32'd0);
        tick();
        check("to_begin_c2", 32'(calc_begin), 32'd1);
        check("to_col2", 32'(calc_column), 32'd2);
        check("to_flag", 32'(timeout_flag), 32'd1);
        check("to_valid", 32'(out_valid), 32'd1);
        check("to_entry_col", 32'(out_column), 32'd1);
        check("to_entry_hgt", 32'(out_height), 32'd0);
        mute_en = 1'b0;
        wait_frame_done(200, "to_frame_done");
        check("to_flag_sticky", 32'(timeout_flag), 32'd1);
        tick();
        frame_pulse();
        check("to_flag_cleared", 32'(timeout_flag), 32'd0);
        wait_frame_done(200, "to_frame2_done");
`else
        check("no_timeout_flag", 32'(timeout_flag), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
